// File: rtl/sram_sp_masked_init_if.sv
// RW0 request/response bundle for the single-port masked SRAM.
// The master drives requests; the slave (the array) returns ready/valid/data.
interface sram_sp_masked_init_if #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WIDTH     = 96,
    parameter int unsigned MASK_GRAN = 48
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MW = WIDTH / MASK_GRAN;

    logic             RW0_en;
    logic             RW0_wmode;
    logic [AW-1:0]    RW0_addr;
    logic [MW-1:0]    RW0_wmask;
    logic [WIDTH-1:0] RW0_wdata;
    logic             RW0_ready;
    logic             RW0_rvalid;
    logic [WIDTH-1:0] RW0_rdata;

    modport master (
        output RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
        input  RW0_ready, RW0_rvalid, RW0_rdata
    );

    modport slave (
        input  RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata,
        output RW0_ready, RW0_rvalid, RW0_rdata
    );
endinterface

// File: rtl/sram_sp_masked_init.sv
// Parametrised single-port masked SRAM model with a hardware init sweep.
// After reset (or an init_req while running) every entry is written with
// INIT_VAL, one entry per cycle; requests are only accepted once the sweep
// has finished. Reads capture the array word at the read edge, so later
// writes never disturb data already returned or held on RW0_rdata.
module sram_sp_masked_init #(
    parameter int unsigned      DEPTH      = 64,
    parameter int unsigned      WIDTH      = 96,
    parameter int unsigned      MASK_GRAN  = 48,
    parameter bit               OUT_REG    = 1'b0,
    parameter bit               HOLD_RDATA = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_sp_masked_init_if.slave  rw0,
    input  logic                  init_req,
    output logic                  init_done
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MW = WIDTH / MASK_GRAN;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Storage; deliberately not reset, the init sweep provides the clean state.
    logic [WIDTH-1:0] ram [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;

    logic             accept;
    logic             addr_in_range;
    logic             rd_accept;
    logic             wr_accept;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [MW-1:0]    mem_wmask;
    logic [WIDTH-1:0] mem_wdata;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    assign accept        = rw0.RW0_en & init_done_q;
    assign addr_in_range = (32'(rw0.RW0_addr) < DEPTH);
    assign rd_accept     = accept & ~rw0.RW0_wmode;
    assign wr_accept     = accept &  rw0.RW0_wmode;

    // Sweep sequencing: walk cnt through every entry, then run until init_req.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Single array write port shared by the sweep and accepted user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = rw0.RW0_addr;
        mem_wmask = rw0.RW0_wmask;
        mem_wdata = rw0.RW0_wdata;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wmask = '1;
            mem_wdata = INIT_VAL;
        end else if (wr_accept && addr_in_range) begin
            mem_we = 1'b1;
        end
    end

    // First read stage: capture the addressed word (0 when out of range) on a read.
    always_comb begin
        s1_valid_d = rd_accept;
        s1_data_d  = s1_data_q;
        if (rd_accept) begin
            s1_data_d = addr_in_range ? ram[rw0.RW0_addr] : '0;
        end
    end

    // Lane-masked array update.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < MW; i++) begin
                if (mem_wmask[i]) begin
                    ram[mem_waddr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Control and first-stage read registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic             s2_valid_q, s2_valid_d;
            logic [WIDTH-1:0] s2_data_q, s2_data_d;

            // Second stage follows stage 1 and loads data only with a valid read.
            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
            end

            // Output register stage.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_data  = s2_data_q;
        end else begin : g_no_out_reg
            assign out_valid = s1_valid_q;
            assign out_data  = s1_data_q;
        end
    endgenerate

    assign init_done      = init_done_q;
    assign rw0.RW0_ready  = init_done_q;
    assign rw0.RW0_rvalid = out_valid;
    assign rw0.RW0_rdata  = (HOLD_RDATA || out_valid) ? out_data : '0;
endmodule

// File: tb/tb_sram_sp_masked_init.sv
// Directed bench for sram_sp_masked_init. Three instances share one stimulus:
//   A: defaults (latency 1, held rdata)
//   B: OUT_REG=1, HOLD_RDATA=0 (latency 2, rdata zero outside valid)
//   C: DEPTH=48 (same address width, upper addresses out of range)
module tb_sram_sp_masked_init;
    logic        clk;
    logic        reset_n;
    logic        en;
    logic        wmode;
    logic [5:0]  addr;
    logic [1:0]  wmask;
    logic [95:0] wdata;
    logic        init_req;
    logic        done_a, done_b, done_c;

    int n_checks;
    int n_errors;

    sram_sp_masked_init_if #(.DEPTH(64), .WIDTH(96), .MASK_GRAN(48)) if_a ();
    sram_sp_masked_init_if #(.DEPTH(64), .WIDTH(96), .MASK_GRAN(48)) if_b ();
    sram_sp_masked_init_if #(.DEPTH(48), .WIDTH(96), .MASK_GRAN(48)) if_c ();

    assign if_a.RW0_en = en;  assign if_a.RW0_wmode = wmode; assign if_a.RW0_addr = addr;
    assign if_a.RW0_wmask = wmask; assign if_a.RW0_wdata = wdata;
    assign if_b.RW0_en = en;  assign if_b.RW0_wmode = wmode; assign if_b.RW0_addr = addr;
    assign if_b.RW0_wmask = wmask; assign if_b.RW0_wdata = wdata;
    assign if_c.RW0_en = en;  assign if_c.RW0_wmode = wmode; assign if_c.RW0_addr = addr;
    assign if_c.RW0_wmask = wmask; assign if_c.RW0_wdata = wdata;

    sram_sp_masked_init #(.DEPTH(64), .WIDTH(96), .MASK_GRAN(48), .OUT_REG(1'b0), .HOLD_RDATA(1'b1))
        u_dut_a (.clock(clk), .reset_n(reset_n), .rw0(if_a.slave), .init_req(init_req), .init_done(done_a));
    sram_sp_masked_init #(.DEPTH(64), .WIDTH(96), .MASK_GRAN(48), .OUT_REG(1'b1), .HOLD_RDATA(1'b0))
        u_dut_b (.clock(clk), .reset_n(reset_n), .rw0(if_b.slave), .init_req(init_req), .init_done(done_b));
    sram_sp_masked_init #(.DEPTH(48), .WIDTH(96), .MASK_GRAN(48), .OUT_REG(1'b0), .HOLD_RDATA(1'b1))
        u_dut_c (.clock(clk), .reset_n(reset_n), .rw0(if_c.slave), .init_req(init_req), .init_done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [1:0]  mask;
        logic [95:0] wdata;
        logic [95:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    localparam logic [95:0] PA   = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [95:0] P5   = 96'h5555_5555_5555_5555_5555_5555;
    localparam logic [95:0] V5A  = {48'h0, 48'hAAAA_AAAA_AAAA};
    localparam logic [95:0] V5B  = {48'h5555_5555_5555, 48'hAAAA_AAAA_AAAA};
    localparam logic [95:0] V63  = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    localparam logic [95:0] VD   = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
    localparam logic [95:0] VX   = 96'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A;
    localparam logic [95:0] ONES = {96{1'b1}};

    function automatic vec_t mkv(input logic w, input logic [5:0] a, input logic [1:0] m,
                                 input logic [95:0] d, input logic [95:0] e);
        vec_t v;
        v.wr = w; v.addr = a; v.mask = m; v.wdata = d; v.exp = e;
        return v;
    endfunction

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_data(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // All drive tasks are entered at a negedge and return at a negedge.
    task automatic do_write(input logic [5:0] a, input logic [1:0] m, input logic [95:0] d);
        en = 1'b1; wmode = 1'b1; addr = a; wmask = m; wdata = d;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] a);
        en = 1'b1; wmode = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Count cycles until A and C report init_done; bounded.
    task automatic count_sweep(output int na, output int nc);
        int n;
        n = 0; na = 0; nc = 0;
        while ((na == 0 || nc == 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (done_a && na == 0) na = n;
            if (done_c && nc == 0) nc = n;
        end
    endtask

    // Back-to-back reads of every address; all must return 0.
    task automatic read_all_zero(input string tag);
        int bad_a, bad_c;
        bad_a = 0; bad_c = 0;
        en = 1'b1; wmode = 1'b0;
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            @(negedge clk);
            if (if_a.RW0_rvalid !== 1'b1 || if_a.RW0_rdata !== 96'h0) bad_a++;
            if (if_c.RW0_rvalid !== 1'b1 || if_c.RW0_rdata !== 96'h0) bad_c++;
        end
        en = 1'b0;
        check_int({tag, "_A_nonzero_reads"}, bad_a, 0);
        check_int({tag, "_C_nonzero_reads"}, bad_c, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nc, n, sawv;
        logic [95:0] expc;

        n_checks = 0; n_errors = 0;
        vecs[0]  = mkv(1'b1, 6'd5,  2'b01, PA,   96'h0);
        vecs[1]  = mkv(1'b0, 6'd5,  2'b00, '0,   V5A);
        vecs[2]  = mkv(1'b1, 6'd5,  2'b10, P5,   96'h0);
        vecs[3]  = mkv(1'b0, 6'd5,  2'b00, '0,   V5B);
        vecs[4]  = mkv(1'b1, 6'd63, 2'b11, V63,  96'h0);
        vecs[5]  = mkv(1'b0, 6'd63, 2'b00, '0,   V63);
        vecs[6]  = mkv(1'b1, 6'd0,  2'b00, ONES, 96'h0);
        vecs[7]  = mkv(1'b0, 6'd0,  2'b00, '0,   96'h0);
        vecs[8]  = mkv(1'b1, 6'd50, 2'b11, VD,   96'h0);
        vecs[9]  = mkv(1'b0, 6'd50, 2'b00, '0,   VD);
        vecs[10] = mkv(1'b0, 6'd5,  2'b00, '0,   V5B);
        vecs[11] = mkv(1'b0, 6'd2,  2'b00, '0,   96'h0);

        reset_n = 1'b0; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0; init_req = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_bit("rst_A_done", done_a, 1'b0);
        check_bit("rst_A_ready", if_a.RW0_ready, 1'b0);
        check_bit("rst_A_rvalid", if_a.RW0_rvalid, 1'b0);
        check_data("rst_A_rdata", if_a.RW0_rdata, 96'h0);
        check_bit("rst_B_rvalid", if_b.RW0_rvalid, 1'b0);
        check_data("rst_B_rdata", if_b.RW0_rdata, 96'h0);

        // Power-up sweep length.
        reset_n = 1'b1;
        count_sweep(na, nc);
        check_int("pwr_sweep_A_cycles", na, 64);
        check_int("pwr_sweep_C_cycles", nc, 48);
        check_bit("pwr_B_done", done_b, 1'b1);
        check_bit("pwr_A_ready", if_a.RW0_ready, 1'b1);
        read_all_zero("pwr");

        // Table-driven writes and reads.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            end else begin
                do_read(vecs[i].addr);
                expc = (int'(vecs[i].addr) >= 48) ? 96'h0 : vecs[i].exp;
                check_bit($sformatf("vec%0d_A_rvalid", i), if_a.RW0_rvalid, 1'b1);
                check_data($sformatf("vec%0d_A_rdata", i), if_a.RW0_rdata, vecs[i].exp);
                check_bit($sformatf("vec%0d_C_rvalid", i), if_c.RW0_rvalid, 1'b1);
                check_data($sformatf("vec%0d_C_rdata", i), if_c.RW0_rdata, expc);
                check_bit($sformatf("vec%0d_B_rvalid_early", i), if_b.RW0_rvalid, 1'b0);
                @(negedge clk);
                check_bit($sformatf("vec%0d_B_rvalid", i), if_b.RW0_rvalid, 1'b1);
                check_data($sformatf("vec%0d_B_rdata", i), if_b.RW0_rdata, vecs[i].exp);
                check_bit($sformatf("vec%0d_A_rvalid_pulse", i), if_a.RW0_rvalid, 1'b0);
                check_data($sformatf("vec%0d_A_rdata_held", i), if_a.RW0_rdata, vecs[i].exp);
            end
        end

        // Captured data: write right after the read must not alter returned data.
        do_read(6'd5);
        check_data("cap_A_rdata", if_a.RW0_rdata, V5B);
        do_write(6'd5, 2'b11, ONES);
        check_bit("cap_B_rvalid", if_b.RW0_rvalid, 1'b1);
        check_data("cap_B_rdata", if_b.RW0_rdata, V5B);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_data($sformatf("hold%0d_A_rdata", k), if_a.RW0_rdata, V5B);
            check_bit($sformatf("hold%0d_A_rvalid", k), if_a.RW0_rvalid, 1'b0);
            check_data($sformatf("hold%0d_B_rdata_zero", k), if_b.RW0_rdata, 96'h0);
        end
        do_read(6'd5);
        check_data("raw_A_rdata", if_a.RW0_rdata, ONES);

        // Back-to-back reads.
        en = 1'b1; wmode = 1'b0; addr = 6'd5;
        @(negedge clk);
        check_bit("b2b0_A_rvalid", if_a.RW0_rvalid, 1'b1);
        check_data("b2b0_A_rdata", if_a.RW0_rdata, ONES);
        addr = 6'd63;
        @(negedge clk);
        en = 1'b0;
        check_bit("b2b1_A_rvalid", if_a.RW0_rvalid, 1'b1);
        check_data("b2b1_A_rdata", if_a.RW0_rdata, V63);
        check_bit("b2b0_B_rvalid", if_b.RW0_rvalid, 1'b1);
        check_data("b2b0_B_rdata", if_b.RW0_rdata, ONES);
        @(negedge clk);
        check_bit("b2b1_B_rvalid", if_b.RW0_rvalid, 1'b1);
        check_data("b2b1_B_rdata", if_b.RW0_rdata, V63);
        check_bit("b2b_A_rvalid_end", if_a.RW0_rvalid, 1'b0);

        // Fill every entry, then restart the sweep with a read in the same cycle.
        en = 1'b1; wmode = 1'b1; wmask = 2'b11;
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i); wdata = 96'(i + 1);
            @(negedge clk);
        end
        en = 1'b1; wmode = 1'b0; addr = 6'd7; init_req = 1'b1;
        @(negedge clk);
        en = 1'b0; init_req = 1'b0;
        check_bit("ireq_A_done_low", done_a, 1'b0);
        check_bit("ireq_A_ready_low", if_a.RW0_ready, 1'b0);
        check_bit("ireq_A_rvalid", if_a.RW0_rvalid, 1'b1);
        check_data("ireq_A_rdata", if_a.RW0_rdata, 96'd8);
        do_write(6'd3, 2'b11, ONES);
        check_bit("ireq_B_rvalid", if_b.RW0_rvalid, 1'b1);
        check_data("ireq_B_rdata", if_b.RW0_rdata, 96'd8);
        n = 1; na = 0; nc = 0; sawv = 0;
        while ((na == 0 || nc == 0) && n < 200) begin
            case (n)
                5:  begin en = 1'b1; wmode = 1'b0; addr = 6'd0; end
                6:  en = 1'b0;
                10: init_req = 1'b1;
                11: init_req = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            n++;
            if (if_a.RW0_rvalid) sawv = 1;
            if (done_a && na == 0) na = n;
            if (done_c && nc == 0) nc = n;
        end
        en = 1'b0; init_req = 1'b0;
        check_int("resweep_A_cycles", na, 64);
        check_int("resweep_C_cycles", nc, 48);
        check_int("resweep_dropped_read_rvalid", sawv, 0);
        read_all_zero("resweep");

        // Async reset in the middle of a sweep.
        do_write(6'd9, 2'b11, VX);
        do_read(6'd9);
        check_data("pre_rst_A_rdata", if_a.RW0_rdata, VX);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_bit("midrst_A_done", done_a, 1'b0);
        check_bit("midrst_A_ready", if_a.RW0_ready, 1'b0);
        check_bit("midrst_A_rvalid", if_a.RW0_rvalid, 1'b0);
        check_data("midrst_A_rdata", if_a.RW0_rdata, 96'h0);
        check_bit("midrst_C_done", done_c, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        count_sweep(na, nc);
        check_int("midrst_sweep_A_cycles", na, 64);
        check_int("midrst_sweep_C_cycles", nc, 48);
        read_all_zero("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
